// File: rtl/k423_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : k423_pkg
//  Purpose  : Shared types and constants for the k423 data-memory responder.
//             - dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//             - DMEM_BE_*    : unshifted byte-enable encodings from the LSU
//             - DMEM_LAT_W   : width of the response-latency counter
//  Revision : 1.0 - initial release
// ============================================================================
package k423_pkg;

  localparam int DMEM_LAT_W = 4;

  localparam logic [3:0] DMEM_BE_BYTE = 4'b0001;
  localparam logic [3:0] DMEM_BE_HALF = 4'b0011;
  localparam logic [3:0] DMEM_BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage : k423_pkg
`default_nettype wire

// File: rtl/k423_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : k423_dmem_array
//  Purpose  : Single-port, byte-writable synchronous word RAM.
//  Ports    : clk   - clock
//             en    - access enable (read always, write lanes per be)
//             be    - per-byte write enables (already lane-aligned)
//             idx   - word index
//             wdata - lane-aligned write data
//             rdata - registered read data (old contents on a write cycle)
//  Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module k423_dmem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule : k423_dmem_array
`default_nettype wire

// File: rtl/k423_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : k423_dmem_resp
//  Purpose  : Slave end of the LSU data-memory interface. Accepts one request
//             per valid/ready handshake, lane-aligns enables and data, accesses
//             the word array on the accept edge, and pulses a response
//             LATENCY cycles after acceptance.
//  Ports    : clk_i, rst_i (sync, active-high)
//             mem_req_vld_i/wen_i/addr_i/wdata_i - request (wen=0000 is a load)
//             mem_req_rdy_o                      - high only in IDLE
//             mem_rsp_vld_o/rdata_o/err_o        - response
//  Config   : K423_DMEM_MISALIGN_CHK_EN - fault misaligned half/word stores
//             (no write, err=1). Undefined: err is always 0 and misaligned
//             stores write only the lanes that land inside the word.
//  Revision : 1.0 - initial release
// ============================================================================
module k423_dmem_resp
  import k423_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_vld_i,
  input  logic [3:0]  mem_req_wen_i,
  input  logic [31:0] mem_req_addr_i,
  input  logic [31:0] mem_req_wdata_i,
  output logic        mem_req_rdy_o,
  output logic        mem_rsp_vld_o,
  output logic [31:0] mem_rsp_rdata_o,
  output logic        mem_rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DMEM_LAT_W-1:0] LAT_M1 = DMEM_LAT_W'(LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]            off_q,   off_d;
  logic                  load_q,  load_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q,   err_d;

  logic        accept;
  logic [1:0]  off;
  logic [7:0]  be_wide;
  logic [3:0]  be_sh;
  logic [31:0] wdata_sh;
  logic        is_store;
  logic        fault;
  logic [31:0] arr_rdata;
  logic [31:0] rsp_rdata_new;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^mem_req_addr_i[31:IDX_W+2];

  assign mem_req_rdy_o = (state_q == IDLE);
  assign accept        = mem_req_vld_i & mem_req_rdy_o;
  assign off           = mem_req_addr_i[1:0];
  assign is_store      = |mem_req_wen_i;

  // Lanes shifted past byte 3 fall off the top and are never written.
  assign be_wide  = {4'b0000, mem_req_wen_i} << off;
  assign be_sh    = be_wide[3:0];
  assign wdata_sh = mem_req_wdata_i << {off, 3'b000};

`ifdef K423_DMEM_MISALIGN_CHK_EN
  assign fault = is_store &
                 (((mem_req_wen_i == DMEM_BE_HALF) && off[0]) ||
                  ((mem_req_wen_i == DMEM_BE_WORD) && (off != 2'b00)));
`else
  assign fault = 1'b0;
`endif

  k423_dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .en    (accept),
    .be    (fault ? 4'b0000 : be_sh),
    .idx   (mem_req_addr_i[IDX_W+1:2]),
    .wdata (wdata_sh),
    .rdata (arr_rdata)
  );

  // Array read data is ready from the cycle after accept and is stable until
  // the next accept, which cannot occur before RESP ends. The RESP cycle
  // therefore presents it directly, and it is captured for the hold period.
  assign rsp_rdata_new = load_q ? (arr_rdata >> {off_q, 3'b000}) : 32'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    load_d  = load_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d   = off;
          load_d  = ~is_store;
          fault_d = fault;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = rsp_rdata_new;
        err_d   = fault_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      load_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      load_q  <= load_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_rsp_vld_o   = (state_q == RESP);
  assign mem_rsp_rdata_o = mem_rsp_vld_o ? rsp_rdata_new : rdata_q;
  assign mem_rsp_err_o   = mem_rsp_vld_o ? fault_q : err_q;

endmodule : k423_dmem_resp
`default_nettype wire

// File: tb/tb_k423_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k423_dmem_resp
//  Purpose  : Directed self-checking bench. Instance u_a runs LATENCY=1,
//             instance u_b runs LATENCY=3; both DEPTH=1024.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_k423_dmem_resp;

  logic clk;
  int   n_vec;
  int   n_err;

  logic        a_rst, a_vld, a_rdy, a_rsp_vld, a_err;
  logic [3:0]  a_wen;
  logic [31:0] a_addr, a_wdata, a_rdata;

  logic        b_rst, b_vld, b_rdy, b_rsp_vld, b_err;
  logic [3:0]  b_wen;
  logic [31:0] b_addr, b_wdata, b_rdata;

  k423_dmem_resp #(.DEPTH(1024), .LATENCY(1)) u_a (
    .clk_i           (clk),
    .rst_i           (a_rst),
    .mem_req_vld_i   (a_vld),
    .mem_req_wen_i   (a_wen),
    .mem_req_addr_i  (a_addr),
    .mem_req_wdata_i (a_wdata),
    .mem_req_rdy_o   (a_rdy),
    .mem_rsp_vld_o   (a_rsp_vld),
    .mem_rsp_rdata_o (a_rdata),
    .mem_rsp_err_o   (a_err)
  );

  k423_dmem_resp #(.DEPTH(1024), .LATENCY(3)) u_b (
    .clk_i           (clk),
    .rst_i           (b_rst),
    .mem_req_vld_i   (b_vld),
    .mem_req_wen_i   (b_wen),
    .mem_req_addr_i  (b_addr),
    .mem_req_wdata_i (b_wdata),
    .mem_req_rdy_o   (b_rdy),
    .mem_rsp_vld_o   (b_rsp_vld),
    .mem_rsp_rdata_o (b_rdata),
    .mem_rsp_err_o   (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One LATENCY=1 transaction, entered and left at posedge+1 with u_a idle.
  task automatic req1(input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic rdy_seen,
                      output logic vld_seen, output logic vld_after,
                      output logic [31:0] rdata, output logic err);
    a_vld = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata;
    rdy_seen = a_rdy;
    @(posedge clk); #1;
    a_vld = 1'b0; a_wen = 4'h0; a_addr = 32'h0; a_wdata = 32'h0;
    vld_seen = a_rsp_vld; rdata = a_rdata; err = a_err;
    @(posedge clk); #1;
    vld_after = a_rsp_vld;
  endtask

  // One LATENCY=3 transaction; early is set if rsp_vld appears before +3.
  task automatic req3(input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic early,
                      output logic vld_seen, output logic [31:0] rdata);
    b_vld = 1'b1; b_wen = wen; b_addr = addr; b_wdata = wdata;
    @(posedge clk); #1;
    b_vld = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    early = b_rsp_vld;
    @(posedge clk); #1;
    early = early | b_rsp_vld;
    @(posedge clk); #1;
    vld_seen = b_rsp_vld; rdata = b_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    n_vec += 8;
    if (a_rdy !== 1'b1)        begin n_err++; $display("FAIL reset_a_rdy got %b exp 1", a_rdy); end
    if (a_rsp_vld !== 1'b0)    begin n_err++; $display("FAIL reset_a_vld got %b exp 0", a_rsp_vld); end
    if (a_rdata !== 32'h0)     begin n_err++; $display("FAIL reset_a_rdata got %h exp 0", a_rdata); end
    if (a_err !== 1'b0)        begin n_err++; $display("FAIL reset_a_err got %b exp 0", a_err); end
    if (b_rdy !== 1'b1)        begin n_err++; $display("FAIL reset_b_rdy got %b exp 1", b_rdy); end
    if (b_rsp_vld !== 1'b0)    begin n_err++; $display("FAIL reset_b_vld got %b exp 0", b_rsp_vld); end
    if (b_rdata !== 32'h0)     begin n_err++; $display("FAIL reset_b_rdata got %h exp 0", b_rdata); end
    if (b_err !== 1'b0)        begin n_err++; $display("FAIL reset_b_err got %b exp 0", b_err); end
  endtask

  task automatic test_word_store_load;
    logic r, v, va, e;
    logic [31:0] d;
    req1(4'hF, 32'h10, 32'hDEADBEEF, r, v, va, d, e);
    n_vec += 5;
    if (r !== 1'b1)      begin n_err++; $display("FAIL wst_rdy got %b exp 1", r); end
    if (v !== 1'b1)      begin n_err++; $display("FAIL wst_vld got %b exp 1", v); end
    if (va !== 1'b0)     begin n_err++; $display("FAIL wst_vld_pulse got %b exp 0", va); end
    if (d !== 32'h0)     begin n_err++; $display("FAIL wst_rdata got %h exp 0", d); end
    if (e !== 1'b0)      begin n_err++; $display("FAIL wst_err got %b exp 0", e); end
    req1(4'h0, 32'h10, 32'h0, r, v, va, d, e);
    n_vec += 2;
    if (v !== 1'b1)          begin n_err++; $display("FAIL wld_vld got %b exp 1", v); end
    if (d !== 32'hDEADBEEF)  begin n_err++; $display("FAIL wld_rdata got %h exp deadbeef", d); end
  endtask

  task automatic test_byte_store;
    logic r, v, va, e;
    logic [31:0] d;
    req1(4'h1, 32'h13, 32'h000000A5, r, v, va, d, e);
    req1(4'h0, 32'h12, 32'h0, r, v, va, d, e);
    n_vec += 2;
    if (d !== 32'h0000A5AD)       begin n_err++; $display("FAIL bld_off2 got %h exp 0000a5ad", d); end
    if (a_rdata !== 32'h0000A5AD) begin n_err++; $display("FAIL bld_hold got %h exp 0000a5ad", a_rdata); end
    req1(4'h0, 32'h10, 32'h0, r, v, va, d, e);
    n_vec += 1;
    if (d !== 32'hA5ADBEEF)       begin n_err++; $display("FAIL bld_word got %h exp a5adbeef", d); end
  endtask

  task automatic test_misaligned;
    logic r, v, va, e;
    logic [31:0] d, exp_w, exp_h, exp_ld;
    logic exp_e;
`ifdef K423_DMEM_MISALIGN_CHK_EN
    exp_e = 1'b1; exp_w = 32'h11223344; exp_h = 32'h11223344;
`else
    exp_e = 1'b0; exp_w = 32'hBBCCDD44; exp_h = 32'h66CCDD44;
`endif
    exp_ld = exp_h >> 8;
    req1(4'hF, 32'h20, 32'h11223344, r, v, va, d, e);
    req1(4'hF, 32'h21, 32'hAABBCCDD, r, v, va, d, e);
    n_vec += 3;
    if (e !== exp_e)  begin n_err++; $display("FAIL mis_word_err got %b exp %b", e, exp_e); end
    if (d !== 32'h0)  begin n_err++; $display("FAIL mis_word_rdata got %h exp 0", d); end
    if (a_err !== exp_e) begin n_err++; $display("FAIL mis_err_hold got %b exp %b", a_err, exp_e); end
    req1(4'h0, 32'h20, 32'h0, r, v, va, d, e);
    n_vec += 2;
    if (d !== exp_w)  begin n_err++; $display("FAIL mis_word_mem got %h exp %h", d, exp_w); end
    if (e !== 1'b0)   begin n_err++; $display("FAIL mis_load_err got %b exp 0", e); end
    req1(4'h3, 32'h23, 32'h00005566, r, v, va, d, e);
    n_vec += 1;
    if (e !== exp_e)  begin n_err++; $display("FAIL mis_half_err got %b exp %b", e, exp_e); end
    req1(4'h0, 32'h21, 32'h0, r, v, va, d, e);
    n_vec += 2;
    if (d !== exp_ld) begin n_err++; $display("FAIL mis_half_mem got %h exp %h", d, exp_ld); end
    if (e !== 1'b0)   begin n_err++; $display("FAIL mis_load_off_err got %b exp 0", e); end
  endtask

  task automatic test_wrap;
    logic r, v, va, e;
    logic [31:0] d;
    req1(4'hF, 32'h1010, 32'hCAFEF00D, r, v, va, d, e);
    req1(4'h0, 32'h10, 32'h0, r, v, va, d, e);
    n_vec += 1;
    if (d !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_low got %h exp cafef00d", d); end
    req1(4'h0, 32'h80000010, 32'h0, r, v, va, d, e);
    n_vec += 1;
    if (d !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_high got %h exp cafef00d", d); end
  endtask

  task automatic test_latency3;
    logic early, v;
    logic [31:0] d;
    bit extra;
    // cycle 10: accept
    b_vld = 1'b1; b_wen = 4'hF; b_addr = 32'h40; b_wdata = 32'h0BADCAFE;
    n_vec += 1;
    if (b_rdy !== 1'b1) begin n_err++; $display("FAIL l3_rdy_c10 got %b exp 1", b_rdy); end
    @(posedge clk); #1;
    // cycle 11: dropped request attempt while busy
    b_wdata = 32'hFFFFFFFF;
    n_vec += 2;
    if (b_rdy !== 1'b0)     begin n_err++; $display("FAIL l3_rdy_c11 got %b exp 0", b_rdy); end
    if (b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL l3_vld_c11 got %b exp 0", b_rsp_vld); end
    @(posedge clk); #1;
    // cycle 12
    b_vld = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    n_vec += 2;
    if (b_rdy !== 1'b0)     begin n_err++; $display("FAIL l3_rdy_c12 got %b exp 0", b_rdy); end
    if (b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL l3_vld_c12 got %b exp 0", b_rsp_vld); end
    @(posedge clk); #1;
    // cycle 13: response
    n_vec += 2;
    if (b_rsp_vld !== 1'b1) begin n_err++; $display("FAIL l3_vld_c13 got %b exp 1", b_rsp_vld); end
    if (b_rdy !== 1'b0)     begin n_err++; $display("FAIL l3_rdy_c13 got %b exp 0", b_rdy); end
    @(posedge clk); #1;
    // cycle 14
    n_vec += 2;
    if (b_rdy !== 1'b1)     begin n_err++; $display("FAIL l3_rdy_c14 got %b exp 1", b_rdy); end
    if (b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL l3_vld_c14 got %b exp 0", b_rsp_vld); end
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b_rsp_vld !== 1'b0) extra = 1'b1;
    end
    n_vec += 1;
    if (extra) begin n_err++; $display("FAIL l3_extra_rsp got 1 exp 0"); end
    req3(4'h0, 32'h40, 32'h0, early, v, d);
    n_vec += 3;
    if (early !== 1'b0)     begin n_err++; $display("FAIL l3_ld_early got %b exp 0", early); end
    if (v !== 1'b1)         begin n_err++; $display("FAIL l3_ld_vld got %b exp 1", v); end
    if (d !== 32'h0BADCAFE) begin n_err++; $display("FAIL l3_ld_rdata got %h exp 0badcafe", d); end
  endtask

  task automatic test_reset_in_wait;
    logic early, v;
    logic [31:0] d;
    bit seen;
    b_vld = 1'b1; b_wen = 4'hF; b_addr = 32'h44; b_wdata = 32'h600DD00D;
    @(posedge clk); #1;
    b_vld = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    n_vec += 1;
    if (b_rdata !== 32'h0BADCAFE) begin n_err++; $display("FAIL rw_hold got %h exp 0badcafe", b_rdata); end
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    n_vec += 3;
    if (b_rdy !== 1'b1)     begin n_err++; $display("FAIL rw_rdy got %b exp 1", b_rdy); end
    if (b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL rw_vld got %b exp 0", b_rsp_vld); end
    if (b_rdata !== 32'h0)  begin n_err++; $display("FAIL rw_rdata got %h exp 0", b_rdata); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b_rsp_vld !== 1'b0) seen = 1'b1;
    end
    n_vec += 1;
    if (seen) begin n_err++; $display("FAIL rw_discard got 1 exp 0"); end
    req3(4'h0, 32'h44, 32'h0, early, v, d);
    n_vec += 2;
    if (v !== 1'b1)         begin n_err++; $display("FAIL rw_ld_vld got %b exp 1", v); end
    if (d !== 32'h600DD00D) begin n_err++; $display("FAIL rw_store_kept got %h exp 600dd00d", d); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    a_rst = 1'b1; a_vld = 1'b0; a_wen = 4'h0; a_addr = 32'h0; a_wdata = 32'h0;
    b_rst = 1'b1; b_vld = 1'b0; b_wen = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_misaligned();
    test_wrap();
    test_latency3();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_k423_dmem_resp
`default_nettype wire

// File: doc/k423_dmem_resp.md
# k423_dmem_resp

Data-memory responder for the k423 core: the slave end of the LSU data-memory request interface. It accepts one request per handshake (valid/ready), aligns byte-enables and write data to the word lane selected by the low address bits, performs the write or read on an internal word-organised array, and returns a one-cycle response pulse after a fixed, parameterised latency. It sits on the data side of the core, between the ex-stage LSU and the wb-stage load path.

## Interface
- `DEPTH`, 1024: array depth in 32-bit words; power of two, minimum 4.
- `LATENCY`, 1: cycles from request acceptance to response pulse; legal range 1..15.
- `clk_i` in 1: core clock; all state changes on the rising edge.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `mem_req_vld_i` in 1: request valid; the LSU may drop it without an accept.
- `mem_req_wen_i` in 4: unshifted byte enables; 0000 = load, 0001 = byte, 0011 = half, 1111 = word store.
- `mem_req_addr_i` in 32: byte address.
- `mem_req_wdata_i` in 32: store data, right-justified (byte/half in the low bits).
- `mem_req_rdy_o` out 1: high only in IDLE.
- `mem_rsp_vld_o` out 1: one-cycle response pulse.
- `mem_rsp_rdata_o` out 32: load data shifted right by `addr[1:0]*8`, zero-filled on the left; 0 for stores.
- `mem_rsp_err_o` out 1: misaligned-store fault, qualified by `mem_rsp_vld_o`.

## Operation
- **Accept condition:** `mem_req_vld_i & mem_req_rdy_o`. On accept, latch:
  - word index `addr[log2(DEPTH)+1:2]` (upper address bits are ignored, so addresses wrap modulo `DEPTH*4`);
  - byte offset `addr[1:0]`;
  - shifted enables `(wen << off)[3:0]`;
  - shifted data `wdata << (off*8)`.
- **Store:** on the accept edge, write each enabled byte lane. Array contents are not reset.
- **Load:** on the accept edge, read the full word and latch it. `rdata` is that word `>> (off*8)`. Sign or zero extension is not done here; the wb stage handles it.
- **FSM states:**
  - IDLE: rdy=1. On accept, go to RESP if `LATENCY==1`, otherwise to WAIT with the counter loaded to `LATENCY-1`.
  - WAIT: rdy=0. Decrement the counter. Go to RESP when the counter reaches 1.
  - RESP: rsp_vld=1 for exactly one cycle, then go to IDLE.
- The response cannot be stalled (no response ready). The next request may be accepted on the cycle after RESP, so throughput is one request per `LATENCY+1` cycles.
- **Request dropped while rdy=0:** ignored, with no side effects.
- **Reset mid-operation:** go to IDLE. An in-flight response is discarded. A store already performed on its accept edge stays written.

## Timing
- **Reset values:** `mem_req_rdy_o`=1, `mem_rsp_vld_o`=0, `mem_rsp_rdata_o`=0, `mem_rsp_err_o`=0, FSM=IDLE, counter=0.
- **Accept in cycle N:** response in cycle `N+LATENCY`.
- **Response outputs:** registered. `rdata` and `err` hold their value until the next RESP; they change only when entering RESP or on reset.
- **`mem_req_rdy_o`:** decoded from the state register only. It is not combinationally dependent on `mem_req_vld_i`.
- **Read-during-write:** not possible, since only one request is outstanding.

## Configuration
- `K423_DMEM_MISALIGN_CHK_EN` defined:
  - A store with wen=0011 and `addr[0]=1` is faulted.
  - A store with wen=1111 and `addr[1:0]!=0` is faulted.
  - A faulted store writes nothing and responds with err=1, rdata=0.
  - Loads are never faulted.
- Undefined:
  - `mem_rsp_err_o` is tied to 0.
  - Misaligned stores write only the shifted lanes that fall inside the word. Bytes shifted past lane 3 are dropped.

## Structure
- Shared package `k423_pkg`:
  - FSM state enum `dmem_state_e` (IDLE, WAIT, RESP).
  - Byte-enable constants `DMEM_BE_BYTE`, `DMEM_BE_HALF`, `DMEM_BE_WORD`.
  - `DMEM_LAT_W` = 4.
- One sub-module, `k423_dmem_array`:
  - single-port, byte-writable synchronous RAM;
  - ports: clk, en, be[3:0], idx, wdata, rdata;
  - rdata is registered on the clock edge.
- FSM, alignment shifters and the misalignment check stay in the top module.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles → rdy=1, rsp_vld=0, rdata=0, err=0.
- **Word store then load, LATENCY=1:** store wen=1111, addr=0x10, wdata=0xDEADBEEF → rsp_vld in the accept cycle +1. Load from 0x10 → rdata=0xDEADBEEF.
- **Byte store then offset load:** store wen=0001, addr=0x13, wdata=0x000000A5 → word 4 becomes 0xA5ADBEEF. Load from 0x12 → rdata=0x0000A5AD.
- **LATENCY=3:**
  - accept at cycle 10 → rdy low during cycles 11–13, rsp_vld pulse at cycle 13, rdy high at cycle 14;
  - vld toggled during cycles 11–12 → no extra accept.
- **Misaligned store:** wen=1111, addr=0x21.
  - With the macro: rsp err=1, word 8 unchanged.
  - Without the macro: only lanes 1–3 written, err=0.
- **Reset in WAIT and address wrap:** assert reset during WAIT → no rsp_vld, rdy=1 next cycle. With DEPTH=1024, an access at addr `0x1000+0x10` hits the same word as 0x10.
